// File: rtl/popcount_pattern_gen.sv
// Streams every WIDTH-bit vector with exactly k ones, in increasing order,
// one per out_valid/out_ready handshake (Gosper's next-combination step).
module popcount_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int IW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             busy,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_last,
  output logic [IW-1:0]    out_index
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  // Trailing-zero count of a one-hot value; stands in for the divide in Gosper's hack.
  function automatic logic [SW-1:0] ctz(input logic [WIDTH-1:0] c);
    logic [SW-1:0] n;
    n = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (c[i]) n = SW'(i);
    end
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] next_comb(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    c = x & (-x);
    r = x + c;
    return (((r ^ x) >> 2) >> ctz(c)) | r;
  endfunction

  logic [0:0]       state;
  logic [WIDTH-1:0] top_vec;
  logic [WIDTH-1:0] start_mask;
  logic [WIDTH-1:0] start_top;
  logic [WIDTH-1:0] nxt_vec;
  logic             hs;

  always_comb begin
    start_mask = ~(ONES << count);
    start_top  = start_mask << (WMAX - count);
    nxt_vec    = next_comb(out_vec);
    hs         = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_vec   <= '0;
      out_index <= '0;
      top_vec   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count > WMAX) begin
              err <= 1'b1;
            end else begin
              state     <= S_EMIT;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_vec   <= start_mask;
              out_index <= '0;
              out_last  <= (start_mask == start_top);
              top_vec   <= start_top;
            end
          end
        end
        S_EMIT: begin
          if (hs) begin
            if (out_last) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_vec   <= nxt_vec;
              out_index <= out_index + 1'b1;
              out_last  <= (nxt_vec == top_vec);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Bench for popcount_pattern_gen: WIDTH=8 and WIDTH=4 instances checked against
// a reference list of all k-ones vectors built by brute-force enumeration.
module tb_popcount_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] count;
  logic       out_ready;
  logic       sel4;

  logic       busy8, err8, valid8, last8;
  logic [7:0] vec8;
  logic [15:0] idx8;
  logic       busy4, err4, valid4, last4;
  logic [3:0] vec4;
  logic [15:0] idx4;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  popcount_pattern_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel4), .count(count),
    .busy(busy8), .err(err8), .out_valid(valid8), .out_ready(out_ready),
    .out_vec(vec8), .out_last(last8), .out_index(idx8)
  );

  popcount_pattern_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start && sel4), .count(count[2:0]),
    .busy(busy4), .err(err4), .out_valid(valid4), .out_ready(out_ready),
    .out_vec(vec4), .out_last(last4), .out_index(idx4)
  );

  wire        o_busy  = sel4 ? busy4  : busy8;
  wire        o_err   = sel4 ? err4   : err8;
  wire        o_valid = sel4 ? valid4 : valid8;
  wire        o_last  = sel4 ? last4  : last8;
  wire [7:0]  o_vec   = sel4 ? {4'b0, vec4} : vec8;
  wire [15:0] o_idx   = sel4 ? idx4 : idx8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full enumeration for k; rnd randomises out_ready, poke fires a stray start mid-run.
  task automatic run_enum(input int k, input bit rnd, input bit poke);
    int exp_q[$];
    int w;
    int i;
    int cyc;
    bit hs;
    w = sel4 ? 4 : 8;
    for (int v = 0; v < (1 << w); v++)
      if ($countones(v) == k) exp_q.push_back(v);
    start = 1'b1;
    count = 4'(k);
    tick();
    start = 1'b0;
    check("accept_busy", o_busy, 1);
    check("accept_valid", o_valid, 1);
    i = 0;
    cyc = 0;
    while (i < exp_q.size() && cyc < 2000) begin
      check("vec", o_vec, exp_q[i]);
      check("index", o_idx, i);
      check("last", o_last, (i == exp_q.size() - 1));
      check("popcount", $countones(o_vec), k);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && i == 2) begin
        start = 1'b1;
        count = 4'd5;
      end
      hs = out_ready && o_valid;
      tick();
      start = 1'b0;
      if (hs) i++;
      cyc++;
    end
    check("vectors_emitted", i, exp_q.size());
    check("end_busy", o_busy, 0);
    check("end_valid", o_valid, 0);
    check("end_last", o_last, 0);
    check("end_err", o_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    count = '0;
    out_ready = 1'b0;
    sel4 = 1'b0;
    tick();
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_vec", o_vec, 0);
    check("rst_index", o_idx, 0);
    rst_n = 1'b1;
    tick();

    sel4 = 1'b1;
    run_enum(2, 1'b0, 1'b0);
    sel4 = 1'b0;
    tick();

    run_enum(0, 1'b0, 1'b0);
    run_enum(8, 1'b0, 1'b0);

    start = 1'b1;
    count = 4'd9;
    tick();
    start = 1'b0;
    check("err_pulse", o_err, 1);
    check("err_busy", o_busy, 0);
    check("err_valid", o_valid, 0);
    tick();
    check("err_clear", o_err, 0);
    check("err_idle_valid", o_valid, 0);

    run_enum(3, 1'b1, 1'b0);
    check("k3_final_vec", o_vec, 8'hE0);

    // Abort a k=4 run after three handshakes.
    out_ready = 1'b1;
    start = 1'b1;
    count = 4'd4;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_rst_index", o_idx, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_valid, 0);
    check("abort_vec", o_vec, 0);
    check("abort_index", o_idx, 0);
    check("abort_last", o_last, 0);
    check("abort_err", o_err, 0);
    tick();
    check("abort_stays_idle", o_valid, 0);
    run_enum(1, 1'b1, 1'b0);

    run_enum(3, 1'b0, 1'b1);

    for (int n = 0; n < 3; n++) run_enum(int'($urandom_range(0, 8)), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
